lpc_word_bridge: RTL
====================

Name: lpc_word_bridge

Overview:
- Upstream feeder for the LPC host cycle engine.
- Accepts byte, halfword and word memory requests from the core over a valid/ready request channel and a valid/ready response channel.
- Splits each request into sequential single-byte LPC memory cycles using the engine's go/done handshake, then reassembles read data little-endian.
- Guards each byte cycle with a timeout so a silent peripheral cannot hang the core.

Parameters:
- TIMEOUT_CYCLES, 255: max lclk cycles go may stay high without done before the byte is aborted; 1..255.
- CNT_W, 8: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- lclk  input  1  LPC clock; all logic on rising edge.
- lreset  input  1  asynchronous reset, active-low (0 = reset); one clock domain only.
- req_valid  input  1  core request present.
- req_ready  output  1  bridge accepts request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as word).
- req_addr  input  32  byte address of lowest byte; no alignment required.
- req_wdata  input  32  write data; byte i on bits [8i+7:8i].
- resp_valid  output  1  response present.
- resp_ready  input  1  core takes response.
- resp_rdata  output  32  read data; unfetched or unused bytes are zero.
- resp_err  output  1  a byte cycle timed out.
- lpc_go  output  1  start and hold LPC cycle.
- lpc_dir  output  1  1 = write, 0 = read.
- lpc_addr  output  32  byte address for the current cycle.
- lpc_write_data  output  8  byte to write.
- lpc_read_data  input  8  byte returned by the engine.
- lpc_done  input  1  engine completion; cleared by the engine when go falls.

Behaviour:
- Reset values (lreset=0, async):
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_err = 0; resp_rdata = 0.
  - lpc_go = 0; lpc_dir = 0; lpc_addr = 0; lpc_write_data = 0.
  - Byte index and timeout counter = 0.
  - Reset mid-transfer drops lpc_go immediately and discards the request; no response is produced.
- States: IDLE, ISSUE, GAP, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch write, size, addr and wdata; set nbytes = 1, 2 or 4; idx = 0; clear the rdata accumulator and err; go to ISSUE.
  - req_ready is registered low from the next cycle.
- ISSUE:
  - lpc_go = 1.
  - lpc_addr = latched addr + idx (32-bit add, wraps at 0xFFFFFFFF).
  - lpc_write_data = wdata byte idx; lpc_dir = write.
  - All outputs are stable for the whole time go is high.
  - Timeout counter increments each cycle in which lpc_done = 0.
  - lpc_done = 1 sampled:
    - On a read, capture lpc_read_data into accumulator byte idx.
    - Clear go next cycle; go to GAP.
  - Counter reaches TIMEOUT_CYCLES with no done:
    - Set err; clear go; go to GAP with abort flagged.
    - Remaining bytes are skipped.
  - Done and timeout in the same cycle: done wins, no error.
- GAP:
  - lpc_go = 0 for at least one cycle.
  - Remain in GAP while lpc_done = 1.
  - Then, if abort or idx = nbytes-1, go to RESP; else idx++, reset the counter, go to ISSUE.
- RESP:
  - resp_valid = 1; resp_rdata = accumulator (zero for writes); resp_err = err.
  - Held stable until resp_ready.
  - resp_valid & resp_ready: go to IDLE.
- Latency:
  - Request accepted at edge T; lpc_go is high from T+1.
  - Minimum per byte: 1 ISSUE cycle with done + 1 GAP cycle.
  - resp_valid rises the cycle after the final GAP.
- A new request is never accepted while a response is pending; one request is outstanding at a time.

Test Plan:
1. Word read, addr 0x000F_FFFC, done returned 3 cycles after each go with bytes 0x11, 0x22, 0x33, 0x44 -> lpc_addr sequence FFFC, FFFD, FFFE, FFFF; resp_rdata = 0x44332211; resp_err = 0.
2. Halfword write, addr 0x0000_1001, wdata 0xAABBCCDD -> two cycles with dir = 1: (0x1001, 0xDD) then (0x1002, 0xCC); resp_rdata = 0; go is low for at least 1 cycle between them.
3. Byte read with done never asserted, TIMEOUT_CYCLES = 8 -> go drops 8 cycles after rising; resp_err = 1; resp_rdata = 0; the next request is accepted normally.
4. Word read where done stays high 4 cycles after go falls -> bridge stays in GAP until done = 0 before asserting go for the next byte.
5. Address wrap: word read at 0xFFFF_FFFE -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
6. Reset pulse during the 2nd byte of a word write -> lpc_go = 0 immediately; resp_valid never asserts; req_ready = 1 after release.

Source files
------------

// File: rtl/lpc_word_bridge.sv
// Splits byte/half/word core requests into single-byte LPC go/done cycles and reassembles read data LE.
// go rises the cycle after accept, 1 ISSUE + 1 GAP cycle minimum per byte; one request in flight, response held until resp_ready.
module lpc_word_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        lclk,
    input  logic        lreset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        lpc_go,
    output logic        lpc_dir,
    output logic [31:0] lpc_addr,
    output logic [7:0]  lpc_write_data,
    input  logic [7:0]  lpc_read_data,
    input  logic        lpc_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, RESP} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q;
    logic               write_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [1:0]         last_q;
    logic [1:0]         idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               abort_q;
    logic [31:0]        acc_q;
    logic               err_q;
    logic               go_q;
    logic               dir_q;
    logic [31:0]        laddr_q;
    logic [7:0]         lwdata_q;
    logic               req_ready_q;
    logic               resp_valid_q;

    logic [1:0]         nidx_d;
    logic [31:0]        naddr_d;
    logic [7:0]         nwdata_d;
    logic [1:0]         last_d;

    always_comb begin
        nidx_d   = idx_q + 2'd1;
        naddr_d  = addr_q + 32'(nidx_d);
        nwdata_d = wdata_q[{nidx_d, 3'b000} +: 8];
        case (req_size)
            2'd0:    last_d = 2'd0;
            2'd1:    last_d = 2'd1;
            default: last_d = 2'd3;
        endcase
    end

    always_ff @(posedge lclk or negedge lreset) begin
        if (!lreset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            acc_q        <= '0;
            err_q        <= 1'b0;
            go_q         <= 1'b0;
            dir_q        <= 1'b0;
            laddr_q      <= '0;
            lwdata_q     <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        last_q      <= last_d;
                        idx_q       <= '0;
                        cnt_q       <= '0;
                        abort_q     <= 1'b0;
                        acc_q       <= '0;
                        err_q       <= 1'b0;
                        go_q        <= 1'b1;
                        dir_q       <= req_write;
                        laddr_q     <= req_addr;
                        lwdata_q    <= req_wdata[7:0];
                        req_ready_q <= 1'b0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // done is checked first so a late done on the timeout edge still counts
                    if (lpc_done) begin
                        if (!write_q) begin
                            acc_q[{idx_q, 3'b000} +: 8] <= lpc_read_data;
                        end
                        go_q    <= 1'b0;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == TO_LAST) begin
                            err_q   <= 1'b1;
                            abort_q <= 1'b1;
                            go_q    <= 1'b0;
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (!lpc_done) begin
                        if (abort_q || idx_q == last_q) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            idx_q    <= nidx_d;
                            cnt_q    <= '0;
                            go_q     <= 1'b1;
                            laddr_q  <= naddr_d;
                            lwdata_q <= nwdata_d;
                            state_q  <= ISSUE;
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = acc_q;
    assign resp_err       = err_q;
    assign lpc_go         = go_q;
    assign lpc_dir        = dir_q;
    assign lpc_addr       = laddr_q;
    assign lpc_write_data = lwdata_q;

endmodule
